pps_capture: RTL
================

// Module: pps_capture
// PURPOSE
//  Receive side of the PPS interface: samples an external 1PPS input, detects rising edges and timestamps
//  each edge against local time-of-day (seconds/subseconds from the T2-MI time tracker).
//  Measures edge-to-edge period and high width in clk cycles, qualifies pulses, tracks lock,
//  and hands one capture record per edge to a consumer over a valid/ready interface.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  nominal period of a good PPS, in clk cycles
//  PERIOD_TOL   1000         allowed |period - CLK_FREQ_HZ|, cycles
//  MIN_WIDTH    100          minimum good high width, cycles
//  MAX_WIDTH    50_000_000   maximum good high width, cycles
//  LOCK_COUNT   3            consecutive good periods required to lock
//  FILTER_LEN   4            glitch filter length, cycles (used only with the filter macro)
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous reset, active-low
//  pps_in          in   1   external PPS, asynchronous to clk
//  tod_seconds     in   40  local seconds since 2000
//  tod_subseconds  in   32  local subseconds (2^-32 s units)
//  cap_valid       out  1   capture record available
//  cap_ready       in   1   consumer accepts record
//  cap_seconds     out  40  tod_seconds at edge detection
//  cap_subseconds  out  32  tod_subseconds at edge detection
//  cap_period      out  32  cycles since previous detected edge (0 for first edge after IDLE)
//  cap_width       out  32  high width of previous pulse, cycles (0 if none)
//  cap_overrun     out  1   1-cycle pulse: edge dropped because record still pending
//  pps_locked      out  1   high only in LOCKED
//  pps_missing     out  1   1-cycle pulse on timeout
//  period_error    out  1   1-cycle pulse on an edge failing qualification in ACQUIRE/LOCKED
//  edge_count      out  32  detected edges since reset, wraps 0xFFFFFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, synchroniser flops 0. Reset mid-operation discards any pending record.
//  - pps_in through 2-FF synchroniser; edge = synced level 1 while previous synced level 0.
//  - Latency: cap_valid rises 3 clk after the first clk edge sampling pps_in high; tod_* sampled on the detection cycle.
//  - Period counter: edges at cycles N and N+P give cap_period = P; saturates at 0xFFFFFFFF.
//  - Width counter: counts cycles synced level high; saturates; latched for the next edge's record.
//  - good edge = period in [CLK_FREQ_HZ-PERIOD_TOL, CLK_FREQ_HZ+PERIOD_TOL] AND width in [MIN_WIDTH, MAX_WIDTH].
//  - timeout = period counter reaches CLK_FREQ_HZ+PERIOD_TOL+1 with no edge; an edge on that same cycle wins (no timeout).
//  - States: IDLE -edge-> ACQUIRE (good_cnt=0, first edge not evaluated).
//    ACQUIRE: good edge -> good_cnt+1, at LOCK_COUNT -> LOCKED; bad edge -> period_error, good_cnt=0; timeout -> IDLE, pps_missing.
//    LOCKED: good edge stays; bad edge -> period_error, ACQUIRE, good_cnt=0; timeout -> HOLDOVER, pps_missing.
//    HOLDOVER: edge -> ACQUIRE (edge not evaluated, good_cnt=0); no further timeout pulses.
//  - Handshake: record transfers on cap_valid & cap_ready; cap_valid drops next cycle unless a new edge is detected that same cycle (then reloads, stays high).
//    Edge while cap_valid & !cap_ready: record unchanged, cap_overrun pulses; state machine, counters, edge_count still update.
//  - cap_* data stable while cap_valid high and not accepted.
// CONFIGURATION
//  PPS_CAPTURE_GLITCH_FILTER_EN defined: filtered level follows synced level only after FILTER_LEN consecutive equal samples;
//    edge detection, width counting use filtered level; latency +FILTER_LEN-1 cycles; pulses shorter than FILTER_LEN ignored.
//  Not defined: no filter, FILTER_LEN ignored, 1-cycle pulses are detected.
// TESTING (bench params CLK_FREQ_HZ=1000, PERIOD_TOL=10, MIN_WIDTH=5, MAX_WIDTH=500, LOCK_COUNT=3, FILTER_LEN=4)
//  1 Reset asserted mid-capture with cap_valid=1 -> all outputs 0, IDLE, next edge gives cap_period=0, cap_width=0.
//  2 4 pulses, period 1000, width 100, cap_ready=1 -> pps_locked=1 after 4th edge; records cap_period=1000, cap_width=100; edge_count=4.
//  3 Locked, next period 1020 -> period_error 1 cycle, pps_locked=0; 3 more good periods -> relock.
//  4 Locked, pulses stop -> pps_missing 1 cycle exactly 1011 cycles after last edge, pps_locked=0; next edge -> ACQUIRE.
//  5 cap_ready=0 across 2 edges -> first record held unchanged, cap_overrun 1 cycle at second edge, edge_count=2.
//  6 2-cycle pulse: with filter -> no record, edge_count unchanged; without -> record with cap_width=2 on next edge, period_error.

Source files
------------

// File: rtl/pps_capture.sv
// pps_capture: 1PPS receiver, ToD timestamping, period/width qualification, lock tracking.
// Build option: define PPS_CAPTURE_GLITCH_FILTER_EN to enable the input glitch filter.
module pps_capture #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned PERIOD_TOL  = 1000,
    parameter int unsigned MIN_WIDTH   = 100,
    parameter int unsigned MAX_WIDTH   = 50_000_000,
    parameter int unsigned LOCK_COUNT  = 3,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pps_in,
    input  logic [39:0] tod_seconds,
    input  logic [31:0] tod_subseconds,
    output logic        cap_valid,
    input  logic        cap_ready,
    output logic [39:0] cap_seconds,
    output logic [31:0] cap_subseconds,
    output logic [31:0] cap_period,
    output logic [31:0] cap_width,
    output logic        cap_overrun,
    output logic        pps_locked,
    output logic        pps_missing,
    output logic        period_error,
    output logic [31:0] edge_count
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACQUIRE  = 2'd1;
    localparam logic [1:0] S_LOCKED   = 2'd2;
    localparam logic [1:0] S_HOLDOVER = 2'd3;

    localparam logic [31:0] P_MIN  = 32'(CLK_FREQ_HZ - PERIOD_TOL);
    localparam logic [31:0] P_MAX  = 32'(CLK_FREQ_HZ + PERIOD_TOL);
    localparam logic [31:0] P_TMO  = 32'(CLK_FREQ_HZ + PERIOD_TOL + 1);
    localparam logic [31:0] W_MIN  = 32'(MIN_WIDTH);
    localparam logic [31:0] W_MAX  = 32'(MAX_WIDTH);
    localparam logic [31:0] LOCK_N = 32'(LOCK_COUNT);
    localparam logic [31:0] SAT    = 32'hFFFF_FFFF;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_lvl;
    logic        r_edge;
    logic        w_lvl_next;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nx;
    logic [31:0] r_good_cnt;
    logic [31:0] w_good_nx;
    logic [31:0] r_per_cnt;
    logic [31:0] r_hi_cnt;
    logic [31:0] r_edge_cnt;

    logic        w_tracking;
    logic        w_period_ok;
    logic        w_width_ok;
    logic        w_good;
    logic        w_timeout;
    logic        w_perr;
    logic        w_load;

    logic        r_cap_valid;
    logic [39:0] r_cap_sec;
    logic [31:0] r_cap_sub;
    logic [31:0] r_cap_per;
    logic [31:0] r_cap_wid;
    logic        r_overrun;
    logic        r_missing;
    logic        r_perr;

`ifdef PPS_CAPTURE_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN) + 1;
    localparam logic [FCW-1:0] F_LAST = FCW'(FILTER_LEN - 1);

    logic [FCW-1:0] r_fcnt;
    logic           w_fswitch;

    // r_lvl only moves after FILTER_LEN consecutive disagreeing samples
    assign w_fswitch  = (r_sync2 != r_lvl) && (r_fcnt == F_LAST);
    assign w_lvl_next = w_fswitch ? r_sync2 : r_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt <= '0;
        end else if ((r_sync2 == r_lvl) || w_fswitch) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end
`else
    assign w_lvl_next = r_sync2;

    if (FILTER_LEN == 0) begin : g_filter_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl   <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync1 <= pps_in;
            r_sync2 <= r_sync1;
            r_lvl   <= w_lvl_next;
            r_edge  <= w_lvl_next & ~r_lvl;
        end
    end

    assign w_tracking  = (r_state == S_ACQUIRE) || (r_state == S_LOCKED);
    assign w_period_ok = (r_per_cnt >= P_MIN) && (r_per_cnt <= P_MAX);
    assign w_width_ok  = (r_hi_cnt >= W_MIN) && (r_hi_cnt <= W_MAX);
    assign w_good      = w_period_ok && w_width_ok;
    // an edge on the timeout cycle takes priority
    assign w_timeout   = w_tracking && !r_edge && (r_per_cnt == P_TMO);

    always_comb begin
        w_state_nx = r_state;
        w_good_nx  = r_good_cnt;
        w_perr     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_edge) begin
                    w_state_nx = S_ACQUIRE;
                    w_good_nx  = '0;
                end
            end
            S_ACQUIRE: begin
                if (r_edge) begin
                    if (w_good) begin
                        w_good_nx = r_good_cnt + 32'd1;
                        if (w_good_nx >= LOCK_N) begin
                            w_state_nx = S_LOCKED;
                        end
                    end else begin
                        w_perr    = 1'b1;
                        w_good_nx = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nx = S_IDLE;
                    w_good_nx  = '0;
                end
            end
            S_LOCKED: begin
                if (r_edge) begin
                    if (!w_good) begin
                        w_perr     = 1'b1;
                        w_state_nx = S_ACQUIRE;
                        w_good_nx  = '0;
                    end
                end else if (w_timeout) begin
                    w_state_nx = S_HOLDOVER;
                end
            end
            S_HOLDOVER: begin
                if (r_edge) begin
                    w_state_nx = S_ACQUIRE;
                    w_good_nx  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_good_cnt <= w_good_nx;
        end
    end

    // period counter idles at 0 so the first edge after IDLE reports 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= '0;
        end else if (r_edge) begin
            r_per_cnt <= 32'd1;
        end else if ((r_state == S_IDLE) || (w_state_nx == S_IDLE)) begin
            r_per_cnt <= '0;
        end else if (r_per_cnt != SAT) begin
            r_per_cnt <= r_per_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi_cnt <= '0;
        end else if (r_edge) begin
            r_hi_cnt <= 32'd1;
        end else if (r_lvl && (r_hi_cnt != SAT)) begin
            r_hi_cnt <= r_hi_cnt + 32'd1;
        end
    end

    assign w_load = r_edge && (!r_cap_valid || cap_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_valid <= 1'b0;
            r_cap_sec   <= '0;
            r_cap_sub   <= '0;
            r_cap_per   <= '0;
            r_cap_wid   <= '0;
        end else if (w_load) begin
            r_cap_valid <= 1'b1;
            r_cap_sec   <= tod_seconds;
            r_cap_sub   <= tod_subseconds;
            r_cap_per   <= r_per_cnt;
            r_cap_wid   <= r_hi_cnt;
        end else if (r_cap_valid && cap_ready) begin
            r_cap_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun  <= 1'b0;
            r_missing  <= 1'b0;
            r_perr     <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_overrun  <= r_edge && r_cap_valid && !cap_ready;
            r_missing  <= w_timeout;
            r_perr     <= w_perr;
            r_edge_cnt <= r_edge_cnt + {31'd0, r_edge};
        end
    end

    assign cap_valid      = r_cap_valid;
    assign cap_seconds    = r_cap_sec;
    assign cap_subseconds = r_cap_sub;
    assign cap_period     = r_cap_per;
    assign cap_width      = r_cap_wid;
    assign cap_overrun    = r_overrun;
    assign pps_locked     = (r_state == S_LOCKED);
    assign pps_missing    = r_missing;
    assign period_error   = r_perr;
    assign edge_count     = r_edge_cnt;

endmodule
